// File: rtl/reg_file_pkg.sv
// Shared datapath defines for the register file.
//   DEF_DATA_W    default register / data-port width
//   DEF_ADDR_W    default register index width (depth = 2**DEF_ADDR_W)
//   REG_ZERO      index of the hard-wired zero register
//   REG_SP        index of the stack pointer register
//   SP_RESET_VAL  value the stack pointer takes on reset
package reg_file_pkg;

    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_ADDR_W   = 5;
    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_SP       = 5'd29;
    localparam logic [31:0] SP_RESET_VAL = 32'd128;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file.
// Selects the addressed entry, forces index 0 to read zero, and (when
// REG_FILE_BYPASS_EN is defined) forwards same-cycle write data when the
// write index matches the read index.
//   addr       in   ADDR_W             read index
//   regs       in   DATA_W x 2**ADDR_W stored register contents
//   fwd_en     in   1                  a qualified write is in flight (REG_FILE_BYPASS_EN only)
//   fwd_addr   in   ADDR_W             write index (REG_FILE_BYPASS_EN only)
//   fwd_data   in   DATA_W             write data (REG_FILE_BYPASS_EN only)
//   rd_data    out  DATA_W             read data
module reg_file_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REG_FILE_BYPASS_EN
    input  logic              fwd_en,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = regs[addr];
        // Entry 0 is never written, but decode it to zero explicitly so the
        // zero register does not depend on storage contents.
        if (addr == '0) begin
            rd_data = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        // fwd_en is already qualified with reset low and a non-zero index.
        if (fwd_en && (fwd_addr == addr)) begin
            rd_data = fwd_data;
        end
`endif
    end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// 32-entry general-purpose register file: two combinational read ports,
// one synchronous write port, register 0 hard-wired to zero, stack pointer
// register initialised to SP_INIT on reset.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write-through
// forwarding onto each read port independently).
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous reset, active-high
//   rs_addr_i    in   ADDR_W  read port A index
//   rt_addr_i    in   ADDR_W  read port B index
//   rd_addr_i    in   ADDR_W  write index
//   rd_data_i    in   DATA_W  write data
//   reg_write_i  in   1       write enable
//   rs_data_o    out  DATA_W  read port A data (ALU operand A)
//   rt_data_o    out  DATA_W  read port B data (ALU-source mux data0_i)
module reg_file
    import reg_file_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 ADDR_W  = DEF_ADDR_W,
    parameter int                 SP_IDX  = int'(REG_SP),
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(SP_RESET_VAL)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rst_val [DEPTH];
    logic [DEPTH-1:0]  wr_sel;
    logic              wr_en;

    // A write only counts when not in reset and not aimed at the zero
    // register; the same qualified enable drives storage and forwarding.
    assign wr_en = reg_write_i && !rst_i && (rd_addr_i != ZERO_IDX);

    // Per-entry write decode and reset value.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign wr_sel[gi]  = wr_en && (rd_addr_i == ADDR_W'(gi));
        assign rst_val[gi] = (gi == SP_IDX) ? SP_INIT : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= rst_val[i];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= rd_data_i;
                end
            end
        end
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_port (
        .addr     (rs_addr_i),
        .regs     (mem_reg),
`ifdef REG_FILE_BYPASS_EN
        .fwd_en   (wr_en),
        .fwd_addr (rd_addr_i),
        .fwd_data (rd_data_i),
`endif
        .rd_data  (rs_data_o)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_port (
        .addr     (rt_addr_i),
        .regs     (mem_reg),
`ifdef REG_FILE_BYPASS_EN
        .fwd_en   (wr_en),
        .fwd_addr (rd_addr_i),
        .fwd_data (rd_data_i),
`endif
        .rd_data  (rt_data_o)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (works with and without
// REG_FILE_BYPASS_EN defined).
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    int checks = 0;
    int errors = 0;

    reg_file dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rs_addr_i   (rs_addr),
        .rt_addr_i   (rt_addr),
        .rd_addr_i   (rd_addr),
        .rd_data_i   (rd_data),
        .reg_write_i (reg_write),
        .rs_data_o   (rs_data),
        .rt_data_o   (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An unknown write enable is illegal input.
    always @(posedge clk) begin
        checks++;
        assert (!$isunknown(reg_write)) else begin
            errors++;
            $error("FAIL we_known: observed %b expected 0/1", reg_write);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-12s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        rd_addr   = a;
        rd_data   = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic read2(input logic [4:0] a, input logic [4:0] b);
        rs_addr = a;
        rt_addr = b;
        #1;
    endtask

    logic [31:0] hazard_exp;

    initial begin
        rst       = 1'b1;
        reg_write = 1'b0;
        rs_addr   = '0;
        rt_addr   = '0;
        rd_addr   = '0;
        rd_data   = '0;

        // 1. Reset: one reset cycle, then every index on both ports.
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read2(5'(i), 5'(31 - i));
            check($sformatf("rst_rs%0d", i), rs_data, (i == 29) ? 32'd128 : 32'd0);
            check($sformatf("rst_rt%0d", 31 - i), rt_data, (31 - i == 29) ? 32'd128 : 32'd0);
        end

        // 2. Write then read on both ports.
        write(5'd5, 32'hDEAD_BEEF);
        read2(5'd5, 5'd5);
        check("wr_r5_rs", rs_data, 32'hDEAD_BEEF);
        check("wr_r5_rt", rt_data, 32'hDEAD_BEEF);

        // Top index is an ordinary register; neighbours untouched.
        write(5'd31, 32'hCAFE_F00D);
        read2(5'd31, 5'd30);
        check("r31_rs", rs_data, 32'hCAFE_F00D);
        check("r30_rt", rt_data, 32'd0);
        read2(5'd0, 5'd1);
        check("r1_rt", rt_data, 32'd0);

        // 3. Zero register: writes ignored, before and after the edge.
        reg_write = 1'b1;
        rd_addr   = 5'd0;
        rd_data   = 32'hFFFF_FFFF;
        read2(5'd0, 5'd0);
        check("r0_pre_rs", rs_data, 32'd0);
        check("r0_pre_rt", rt_data, 32'd0);
        tick();
        reg_write = 1'b0;
        read2(5'd0, 5'd0);
        check("r0_post_rs", rs_data, 32'd0);
        check("r0_post_rt", rt_data, 32'd0);

        // 4. Same-cycle read/write hazard on rt; rs watches another register.
        write(5'd7, 32'h11);
        reg_write = 1'b1;
        rd_addr   = 5'd7;
        rd_data   = 32'h22;
        read2(5'd8, 5'd7);
`ifdef REG_FILE_BYPASS_EN
        hazard_exp = 32'h22;
`else
        hazard_exp = 32'h11;
`endif
        check("haz_pre_rt", rt_data, hazard_exp);
        check("haz_pre_rs8", rs_data, 32'd0);
        tick();
        reg_write = 1'b0;
        read2(5'd7, 5'd7);
        check("haz_post_rs", rs_data, 32'h22);
        check("haz_post_rt", rt_data, 32'h22);

        // 6. Disabled write leaves r9 unchanged.
        write(5'd9, 32'h99);
        reg_write = 1'b0;
        rd_addr   = 5'd9;
        rd_data   = 32'hAA;
        read2(5'd9, 5'd9);
        check("nowr_pre", rs_data, 32'h99);
        tick();
        read2(5'd9, 5'd9);
        check("nowr_post", rt_data, 32'h99);

        // 5. Reset mid-write: the write is discarded, SP reloads.
        write(5'd3, 32'h33);
        write(5'd29, 32'h1000);
        read2(5'd3, 5'd29);
        check("pre_rst_r3", rs_data, 32'h33);
        check("pre_rst_sp", rt_data, 32'h1000);
        rst       = 1'b1;
        reg_write = 1'b1;
        rd_addr   = 5'd3;
        rd_data   = 32'h55;
        #1;
        check("rstwr_pre_r3", rs_data, 32'h33);
        tick();
        rst       = 1'b0;
        reg_write = 1'b0;
        read2(5'd3, 5'd29);
        check("rstwr_r3", rs_data, 32'd0);
        check("rstwr_sp", rt_data, 32'd128);
        read2(5'd5, 5'd9);
        check("rstwr_r5", rs_data, 32'd0);
        check("rstwr_r9", rt_data, 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_reg_file
